// File: rtl/seven_segment_arbiter.sv
// Round-robin owner selection for the two seven-segment digits, with a minimum
// hold before a contested owner is revoked and a blank gap between owners.
module seven_segment_arbiter #(
  parameter int unsigned g_HOLD_CYCLES = 25000000/2,
  parameter int unsigned g_GAP_CYCLES  = 25000/10
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [2:0] i_Req,
  input  logic [7:0] i_Data0,
  input  logic [7:0] i_Data1,
  input  logic [7:0] i_Data2,
  output logic [2:0] o_Grant,
  output logic       o_Busy,
  output logic [6:0] o_Seg_Upper,
  output logic [6:0] o_Seg_Lower
);

  localparam int unsigned HW = (g_HOLD_CYCLES > 1) ? $clog2(g_HOLD_CYCLES) : 1;
  localparam int unsigned GW = (g_GAP_CYCLES > 1) ? $clog2(g_GAP_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(g_HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_MAX  = GW'(g_GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      4'hF: return 7'h71;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [1:0] rr_next(input logic [1:0] i);
    case (i)
      2'd0:    return 2'd1;
      2'd1:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // Search order last+1, last+2, last; caller guarantees some request is high.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = rr_next(last);
    c2 = rr_next(c1);
    if (req[c1]) begin
      return c1;
    end else if (req[c2]) begin
      return c2;
    end else begin
      return last;
    end
  endfunction

  function automatic logic [2:0] one_hot(input logic [1:0] i);
    case (i)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [7:0] sel_data(input logic [1:0] i, input logic [7:0] a,
                                          input logic [7:0] b, input logic [7:0] c);
    case (i)
      2'd0:    return a;
      2'd1:    return b;
      2'd2:    return c;
      default: return 8'h00;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [1:0]    last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [2:0]    grant_q, grant_d;
  logic          busy_q, busy_d;
  logic [6:0]    seg_u_q, seg_u_d;
  logic [6:0]    seg_l_q, seg_l_d;

  logic [1:0] win_s;
  logic [7:0] win_data_s;
  logic [7:0] own_data_s;
  logic       owner_req_s;
  logic       other_req_s;

  assign win_s       = rr_pick(i_Req, last_q);
  assign win_data_s  = sel_data(win_s, i_Data0, i_Data1, i_Data2);
  assign own_data_s  = sel_data(last_q, i_Data0, i_Data1, i_Data2);
  assign owner_req_s = |(i_Req & one_hot(last_q));
  assign other_req_s = |(i_Req & ~one_hot(last_q));

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    seg_u_d = seg_u_q;
    seg_l_d = seg_l_q;
    case (state_q)
      S_IDLE: begin
        if (|i_Req) begin
          state_d = S_OWN;
          last_d  = win_s;
          hold_d  = '0;
          grant_d = one_hot(win_s);
          busy_d  = 1'b1;
          seg_u_d = hex_decode(win_data_s[7:4]);
          seg_l_d = hex_decode(win_data_s[3:0]);
        end else begin
          grant_d = 3'b000;
          busy_d  = 1'b0;
          seg_u_d = 7'h00;
          seg_l_d = 7'h00;
        end
      end
      S_OWN: begin
        // Release is immediate; revocation needs the full hold and a rival.
        if (!owner_req_s || ((hold_q == HOLD_MAX) && other_req_s)) begin
          state_d = S_GAP;
          gap_d   = '0;
          grant_d = 3'b000;
          busy_d  = 1'b1;
          seg_u_d = 7'h00;
          seg_l_d = 7'h00;
        end else begin
          grant_d = one_hot(last_q);
          busy_d  = 1'b1;
          seg_u_d = hex_decode(own_data_s[7:4]);
          seg_l_d = hex_decode(own_data_s[3:0]);
          if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HW'(1);
          end else begin
            hold_d = hold_q;
          end
        end
      end
      S_GAP: begin
        grant_d = 3'b000;
        busy_d  = 1'b1;
        seg_u_d = 7'h00;
        seg_l_d = 7'h00;
        if (gap_q == GAP_MAX) begin
          if (|i_Req) begin
            state_d = S_OWN;
            last_d  = win_s;
            hold_d  = '0;
            grant_d = one_hot(win_s);
            seg_u_d = hex_decode(win_data_s[7:4]);
            seg_l_d = hex_decode(win_data_s[3:0]);
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        last_d  = 2'd2;
        hold_d  = '0;
        gap_d   = '0;
        grant_d = 3'b000;
        busy_d  = 1'b0;
        seg_u_d = 7'h00;
        seg_l_d = 7'h00;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= S_IDLE;
      last_q  <= 2'd2;
      hold_q  <= '0;
      gap_q   <= '0;
      grant_q <= 3'b000;
      busy_q  <= 1'b0;
      seg_u_q <= 7'h00;
      seg_l_q <= 7'h00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      seg_u_q <= seg_u_d;
      seg_l_q <= seg_l_d;
    end
  end

  assign o_Grant     = grant_q;
  assign o_Busy      = busy_q;
  assign o_Seg_Upper = seg_u_q;
  assign o_Seg_Lower = seg_l_q;

endmodule

// File: tb/tb_seven_segment_arbiter.sv
// Scoreboarded bench: a cycle-level ownership model predicts outputs per edge,
// and an independent monitor compares them one cycle later.
module tb_seven_segment_arbiter;

  localparam int HOLD = 4;
  localparam int GAP  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req;
  logic [7:0] d0, d1, d2;
  logic [2:0] grant;
  logic       busy;
  logic [6:0] seg_up, seg_lo;

  always #5 clk = ~clk;

  seven_segment_arbiter #(.g_HOLD_CYCLES(HOLD), .g_GAP_CYCLES(GAP)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Req(req),
    .i_Data0(d0), .i_Data1(d1), .i_Data2(d2),
    .o_Grant(grant), .o_Busy(busy), .o_Seg_Upper(seg_up), .o_Seg_Lower(seg_lo)
  );

  typedef struct packed {
    logic [2:0] grant;
    logic       busy;
    logic [6:0] up;
    logic [6:0] lo;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model state: who owns the display, how long, remaining blank cycles.
  int m_owner = -1;
  int m_last  = 2;
  int m_held  = 0;
  int m_gap   = 0;

  function automatic exp_t show(input int who, input logic [7:0] v);
    exp_t e;
    e.grant = 3'(1 << who);
    e.busy  = 1'b1;
    e.up    = seg_tab[v[7:4]];
    e.lo    = seg_tab[v[3:0]];
    return e;
  endfunction

  task automatic arbitrate(input logic [2:0] rq, input logic [7:0] dv [3], inout exp_t e);
    for (int d = 1; d <= 3; d++) begin
      int c;
      c = (m_last + d) % 3;
      if (rq[c] && m_owner < 0) begin
        m_owner = c;
        m_last  = c;
        m_held  = 1;
        e = show(c, dv[c]);
      end
    end
  endtask

  task automatic model_step(input logic r, input logic [2:0] rq, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] c, output exp_t e);
    logic [7:0] dv [3];
    logic other;
    dv = '{a, b, c};
    e = '0;
    if (!r) begin
      m_owner = -1; m_last = 2; m_held = 0; m_gap = 0;
    end else if (m_gap > 0) begin
      if (m_gap == 1) begin
        m_gap = 0;
        arbitrate(rq, dv, e);
      end else begin
        m_gap--;
        e.busy = 1'b1;
      end
    end else if (m_owner >= 0) begin
      other = 1'b0;
      for (int k = 0; k < 3; k++) if (k != m_owner && rq[k]) other = 1'b1;
      if (!rq[m_owner] || (m_held >= HOLD && other)) begin
        m_owner = -1;
        m_gap   = GAP;
        e.busy  = 1'b1;
      end else begin
        m_held++;
        e = show(m_owner, dv[m_owner]);
      end
    end else begin
      arbitrate(rq, dv, e);
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] rq, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] c);
    exp_t e;
    @(negedge clk);
    rst_n = r; req = rq; d0 = a; d1 = b; d2 = c;
    model_step(r, rq, a, b, c, e);
    exp_q.push_back(e);
  endtask

  // Monitor: one expectation per edge, popped just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        total++;
        if ({grant, busy, seg_up, seg_lo} !== e) begin
          bad++;
          $display("FAIL outputs t=%0t: got grant=%b busy=%b up=%h lo=%h, want grant=%b busy=%b up=%h lo=%h",
                   $time, grant, busy, seg_up, seg_lo, e.grant, e.busy, e.up, e.lo);
        end
      end
    end
  end

  initial begin
    logic [2:0] rq;
    rst_n = 1'b0; req = 3'b000; d0 = 8'h00; d1 = 8'h00; d2 = 8'h00;
    repeat (3) drive(1'b0, 3'b000, 8'h00, 8'h00, 8'h00);
    repeat (3) drive(1'b1, 3'b000, 8'h00, 8'h00, 8'h00);
    repeat (3) drive(1'b1, 3'b001, 8'h3A, 8'h11, 8'h22);
    repeat (3) drive(1'b1, 3'b001, 8'hF0, 8'h11, 8'h22);
    repeat (4) drive(1'b1, 3'b000, 8'hF0, 8'h11, 8'h22);

    repeat (3) drive(1'b1, 3'b001, 8'h5C, 8'h11, 8'h22);
    drive(1'b0, 3'b001, 8'h5C, 8'h11, 8'h22);
    #1;
    total++;
    if ({grant, busy, seg_up, seg_lo} !== 18'd0) begin
      bad++;
      $display("FAIL async_reset: got grant=%b busy=%b up=%h lo=%h, want all zero",
               grant, busy, seg_up, seg_lo);
    end
    repeat (2) drive(1'b0, 3'b000, 8'h00, 8'h00, 8'h00);
    repeat (3) drive(1'b1, 3'b000, 8'h00, 8'h00, 8'h00);

    drive(1'b0, 3'b000, 8'h00, 8'h00, 8'h00);
    repeat (30) drive(1'b1, 3'b111, 8'h01, 8'h23, 8'h45);

    drive(1'b0, 3'b000, 8'h00, 8'h00, 8'h00);
    repeat (50) drive(1'b1, 3'b010, 8'($urandom()), 8'($urandom()), 8'($urandom()));

    drive(1'b0, 3'b000, 8'h00, 8'h00, 8'h00);
    repeat (4) drive(1'b1, 3'b001, 8'h67, 8'h89, 8'hAB);
    repeat (8) drive(1'b1, 3'b010, 8'h67, 8'h89, 8'hAB);

    rq = 3'b000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) rq = 3'($urandom());
      drive(($urandom_range(0, 199) != 0), rq,
            8'($urandom()), 8'($urandom()), 8'($urandom()));
    end

    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
